// File: rtl/edge_event_sync.sv
// Multi-channel edge event synchronizer: per-channel sync chain, glitch filter,
// edge qualification, sticky pending flag and wrapping event counter.
module edge_event_sync #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [CHANNELS-1:0]             din,
  input  logic [2*CHANNELS-1:0]           mode,
  input  logic [CHANNELS-1:0]             clr,
  input  logic                            cnt_clr,
  output logic [CHANNELS-1:0]             pulse,
  output logic [CHANNELS-1:0]             level,
  output logic [CHANNELS-1:0]             pending,
  output logic [CHANNELS-1:0]             overflow,
  output logic [CHANNELS*COUNT_WIDTH-1:0] count,
  output logic                            irq
);

  localparam int FCW = $clog2(FILTER_CYCLES) + 1;

  logic irq_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [FCW-1:0]         fcnt_reg;
      logic                   level_reg;
      logic                   pulse_reg;
      logic                   pending_reg;
      logic                   overflow_reg;
      logic [COUNT_WIDTH-1:0] count_reg;
      logic                   s;
      logic                   accept;
      logic                   pulse_next;

      assign s      = sync_reg[SYNC_STAGES-1];
      assign accept = (s != level_reg) && (fcnt_reg == FCW'(FILTER_CYCLES - 1));
      // New level 1 means a rising edge (mode bit 0), 0 a falling edge (mode bit 1).
      assign pulse_next = accept && (s ? mode[2*gi] : mode[2*gi+1]);

      always_ff @(posedge aclk) begin
        if (!aresetn) begin
          sync_reg     <= '0;
          fcnt_reg     <= '0;
          level_reg    <= 1'b0;
          pulse_reg    <= 1'b0;
          pending_reg  <= 1'b0;
          overflow_reg <= 1'b0;
          count_reg    <= '0;
        end else begin
          sync_reg  <= {sync_reg[SYNC_STAGES-2:0], din[gi]};
          pulse_reg <= pulse_next;

          if (s == level_reg) begin
            fcnt_reg <= '0;
          end else if (accept) begin
            level_reg <= s;
            fcnt_reg  <= '0;
          end else begin
            fcnt_reg <= fcnt_reg + FCW'(1);
          end

          if (pulse_reg) begin
            pending_reg <= 1'b1;
          end else if (clr[gi]) begin
            pending_reg <= 1'b0;
          end

          // A clear coinciding with an event keeps that event counted.
          if (cnt_clr) begin
            count_reg    <= pulse_reg ? COUNT_WIDTH'(1) : '0;
            overflow_reg <= 1'b0;
          end else if (pulse_reg) begin
            count_reg <= count_reg + COUNT_WIDTH'(1);
            if (&count_reg) begin
              overflow_reg <= 1'b1;
            end
          end
        end
      end

      assign pulse[gi]                              = pulse_reg;
      assign level[gi]                              = level_reg;
      assign pending[gi]                            = pending_reg;
      assign overflow[gi]                           = overflow_reg;
      assign count[gi*COUNT_WIDTH +: COUNT_WIDTH]   = count_reg;
    end
  endgenerate

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= |pending;
    end
  end

  assign irq = irq_reg;

endmodule

// File: tb/tb_edge_event_sync.sv
// Directed bench for edge_event_sync (4 channels, 2 sync stages, filter 3, 4-bit counters).
module tb_edge_event_sync;

  localparam int CH = 4;
  localparam int CW = 4;

  logic            aclk;
  logic            aresetn;
  logic [CH-1:0]   din;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   clr;
  logic            cnt_clr;
  logic [CH-1:0]   pulse;
  logic [CH-1:0]   level;
  logic [CH-1:0]   pending;
  logic [CH-1:0]   overflow;
  logic [CH*CW-1:0] count;
  logic            irq;

  int n_cmp = 0;
  int n_err = 0;
  int pc [CH];
  int snap [CH];

  edge_event_sync #(
    .CHANNELS(CH), .SYNC_STAGES(2), .FILTER_CYCLES(3), .COUNT_WIDTH(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .din(din), .mode(mode), .clr(clr),
    .cnt_clr(cnt_clr), .pulse(pulse), .level(level), .pending(pending),
    .overflow(overflow), .count(count), .irq(irq)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial for (int i = 0; i < CH; i++) pc[i] = 0;

  // Pulses are one full cycle wide, so each is seen at exactly one falling edge.
  always @(negedge aclk) begin
    for (int i = 0; i < CH; i++) if (pulse[i]) pc[i] = pc[i] + 1;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [CW-1:0] cnt(input int i);
    return count[i*CW +: CW];
  endfunction

  task automatic take_snap();
    for (int i = 0; i < CH; i++) snap[i] = pc[i];
  endtask

  initial begin
    aresetn = 1'b0; din = '0; mode = '0; clr = '0; cnt_clr = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_pulse", 32'(pulse), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // 1. Rising edge on ch0
    mode = 8'b11_11_11_01;
    aresetn = 1'b1;
    repeat (3) tick();
    din[0] = 1'b1;
    repeat (4) tick();
    check("t1_pulse_e4", 32'(pulse), 32'h0);
    tick();
    check("t1_pulse_e5", 32'(pulse), 32'h1);
    check("t1_level_e5", 32'(level), 32'h1);
    tick();
    check("t1_pulse_e6", 32'(pulse), 32'h0);
    check("t1_pending_e6", 32'(pending), 32'h1);
    check("t1_count0_e6", 32'(cnt(0)), 32'h1);
    check("t1_irq_e6", 32'(irq), 32'h0);
    tick();
    check("t1_irq_e7", 32'(irq), 32'h1);
    check("t1_count_others", 32'(count[CH*CW-1:CW]), 32'h0);

    // 2. Glitch filter on ch1
    take_snap();
    din[1] = 1'b1; tick(); tick(); din[1] = 1'b0;
    repeat (10) tick();
    check("t2_glitch_pulses", 32'(pc[1] - snap[1]), 32'h0);
    check("t2_glitch_level", 32'(level[1]), 32'h0);
    check("t2_glitch_count", 32'(cnt(1)), 32'h0);
    din[1] = 1'b1; repeat (3) tick(); din[1] = 1'b0;
    repeat (2) tick();
    check("t2_rise_pulse", 32'(pulse), 32'h2);
    repeat (10) tick();
    check("t2_pulses", 32'(pc[1] - snap[1]), 32'h2);
    check("t2_level", 32'(level[1]), 32'h0);
    check("t2_count1", 32'(cnt(1)), 32'h2);

    // 3. Mode select on ch2
    take_snap();
    for (int k = 0; k < 6; k++) begin din[2] = ~din[2]; repeat (10) tick(); end
    check("t3_both_pulses", 32'(pc[2] - snap[2]), 32'h6);
    check("t3_both_count", 32'(cnt(2)), 32'h6);
    mode[5:4] = 2'b10;
    take_snap();
    for (int k = 0; k < 6; k++) begin din[2] = ~din[2]; repeat (10) tick(); end
    check("t3_fall_pulses", 32'(pc[2] - snap[2]), 32'h3);
    check("t3_fall_count", 32'(cnt(2)), 32'h9);
    mode[5:4] = 2'b00;
    take_snap();
    for (int k = 0; k < 6; k++) begin
      din[2] = ~din[2]; repeat (10) tick();
      check("t3_off_level", 32'(level[2]), 32'(din[2]));
    end
    check("t3_off_pulses", 32'(pc[2] - snap[2]), 32'h0);
    check("t3_off_count", 32'(cnt(2)), 32'h9);
    check("t3_off_overflow", 32'(overflow[2]), 32'h0);

    // 4. Counter wrap on ch3
    for (int k = 0; k < 17; k++) begin din[3] = ~din[3]; repeat (8) tick(); end
    check("t4_wrap_count", 32'(cnt(3)), 32'h1);
    check("t4_wrap_overflow", 32'(overflow), 32'h8);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("t4_clr_count", 32'(count), 32'h0);
    check("t4_clr_overflow", 32'(overflow), 32'h0);
    din[3] = 1'b0;
    repeat (5) tick();
    check("t4_pulse3", 32'(pulse), 32'h8);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("t4_coinc_count", 32'(cnt(3)), 32'h1);
    check("t4_coinc_overflow", 32'(overflow[3]), 32'h0);

    // 5. Pending clear
    clr = 4'hF; tick(); clr = '0;
    check("t5_clr_all", 32'(pending), 32'h0);
    tick();
    check("t5_irq_low", 32'(irq), 32'h0);
    mode[1:0] = 2'b11;
    din[0] = 1'b0;
    repeat (5) tick();
    check("t5_pulse0", 32'(pulse), 32'h1);
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    check("t5_set_wins", 32'(pending), 32'h1);
    tick();
    check("t5_irq_high", 32'(irq), 32'h1);
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    check("t5_clr_alone", 32'(pending), 32'h0);
    check("t5_irq_lag", 32'(irq), 32'h1);
    tick();
    check("t5_irq_clear", 32'(irq), 32'h0);

    // 6. Reset mid-filter, din[0] held high through release
    take_snap();
    din[0] = 1'b1;
    repeat (3) tick();
    aresetn = 1'b0; tick();
    check("t6_rst_pulse", 32'(pulse), 32'h0);
    check("t6_rst_level", 32'(level), 32'h0);
    check("t6_rst_pending", 32'(pending), 32'h0);
    check("t6_rst_count", 32'(count), 32'h0);
    check("t6_rst_irq", 32'(irq), 32'h0);
    aresetn = 1'b1;
    repeat (4) tick();
    check("t6_pulse_e4", 32'(pulse), 32'h0);
    tick();
    check("t6_pulse_e5", 32'(pulse), 32'h1);
    check("t6_level_e5", 32'(level), 32'h1);
    repeat (10) tick();
    check("t6_pulses0", 32'(pc[0] - snap[0]), 32'h1);
    check("t6_pulses_other", 32'((pc[1] - snap[1]) + (pc[2] - snap[2]) + (pc[3] - snap[3])), 32'h0);
    check("t6_count0", 32'(cnt(0)), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
